ram_dma_engine: RTL and testbench
=================================

RAM_DMA_ENGINE -- requirements
Module: ram_dma_engine

Interface
REQ-001 The block SHALL have parameter DEPTH, default 96, meaning number of addressable RAM bytes (addresses 0..DEPTH-1).
REQ-002 The block SHALL have parameter AW, default 7, meaning RAM address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock; port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1: request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, 1: 0 = copy, 1 = fill.
REQ-006 The block SHALL have port src_addr, input, AW: copy source start address.
REQ-007 The block SHALL have port dst_addr, input, AW: destination start address.
REQ-008 The block SHALL have port length, input, AW: byte count, 0..127.
REQ-009 The block SHALL have port fill_val, input, 8: fill byte.
REQ-010 The block SHALL have port abort, input, 1: synchronous stop request.
REQ-011 The block SHALL have port mem_addr, output, AW: RAM address.
REQ-012 The block SHALL have port mem_write, output, 1: RAM write enable, synchronous-write RAM.
REQ-013 The block SHALL have port mem_wdata, output, 8: RAM write data.
REQ-014 The block SHALL have port mem_rdata, input, 8: RAM combinational read data for mem_addr.
REQ-015 The block SHALL have status outputs busy (1), done (1), err (1) and remaining (AW, bytes still to be written).

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL latch mode, src_addr, dst_addr, length and fill_val; input changes after acceptance SHALL have no effect.
REQ-018 On acceptance with length=0 or length>DEPTH or src_addr>=DEPTH or dst_addr>=DEPTH, the block SHALL go to DONE with err=1 and perform no write.
REQ-019 On acceptance of a valid request, the block SHALL go to READ for copy and to WRITE for fill; remaining SHALL load length.
REQ-020 In READ, mem_addr SHALL equal the source pointer, mem_write SHALL be 0, and mem_rdata SHALL be captured into a holding register at the clock edge; the next state SHALL be WRITE.
REQ-021 In WRITE, mem_addr SHALL equal the destination pointer, mem_write SHALL be 1, and mem_wdata SHALL be the holding register (copy) or fill_val (fill).
REQ-022 At each WRITE edge, both pointers SHALL increment, wrapping DEPTH-1 -> 0, and remaining SHALL decrement.
REQ-023 After a WRITE, if remaining becomes 0 the next state SHALL be DONE; otherwise the next state SHALL be READ (copy) or WRITE (fill).
REQ-024 Copy SHALL take 2*length busy cycles and fill SHALL take length busy cycles.
REQ-025 Copy SHALL proceed strictly ascending, byte by byte; with overlapping regions where dst>src, already-written bytes SHALL be re-read (defined behaviour, no correction).
REQ-026 busy SHALL be 1 exactly in READ and WRITE.
REQ-027 done SHALL be 1 for exactly one cycle, in DONE, which SHALL always return to IDLE on the next edge.
REQ-028 err SHALL be valid while done=1 and SHALL hold until the next accepted start.
REQ-029 start SHALL be ignored in READ, WRITE and DONE.
REQ-030 abort=1 in READ or WRITE SHALL go to DONE at the next edge, with err=1; a WRITE that coincides with abort SHALL still be committed, and remaining SHALL reflect it.
REQ-031 abort=1 in IDLE or DONE SHALL be ignored; if start and abort are both 1 in IDLE, start SHALL win.
REQ-032 In IDLE and DONE, mem_write SHALL be 0 and mem_addr SHALL be 0.
REQ-033 mem_write SHALL be decoded from registered state only, so that no write pulse occurs outside WRITE.

Reset
REQ-034 While reset=0, the state SHALL be IDLE, busy=0, done=0, err=0, remaining=0, mem_write=0, mem_addr=0, mem_wdata=0, and the pointers and holding register SHALL be 0; this SHALL take effect immediately, without a clock edge.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer with no further writes; bytes already written SHALL remain in the RAM.
REQ-036 After reset is released, the block SHALL accept start at the first rising edge.

Verification
REQ-037 Fill scenario: mode=1, dst=10, length=4, fill_val=0xA5 -> writes at 10,11,12,13 on 4 consecutive cycles; done pulse on the 5th cycle; err=0.
REQ-038 Copy scenario: RAM[0]=0x33, RAM[1]=0x22, mode=0, src=0, dst=50, length=2 -> RAM[50]=0x33, RAM[51]=0x22; busy for 4 cycles; done once.
REQ-039 Wrap scenario: fill dst=94, length=4, fill_val=0x11 -> writes at 94,95,0,1; no write at address 96 or above.
REQ-040 Error scenario: length=0, then length=97, then dst=100 -> each request gives done with err=1 one cycle after start and zero mem_write pulses.
REQ-041 Abort scenario: fill dst=20, length=10, abort asserted in the 3rd WRITE -> exactly 3 writes (20..22); remaining=7; done with err=1.
REQ-042 Reset scenario: reset=0 mid-copy (during READ) -> all outputs go to their reset values immediately with no write; a new fill after release completes normally.

Source files
------------

// File: rtl/ram_dma_engine.sv
// Byte-wide DMA engine that copies or fills a region of a synchronous-write RAM.
// Copy alternates READ/WRITE per byte; fill writes on every busy cycle.
module ram_dma_engine #(
    parameter int DEPTH = 96,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] length,
    input  logic [7:0]    fill_val,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic          mode_q;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic [7:0]    fill_q, hold_q;
    logic          err_q;
    logic          req_bad;

    function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        req_bad = (length == '0)
               || ({1'b0, length}   >  DEPTH_L)
               || ({1'b0, src_addr} >= DEPTH_L)
               || ({1'b0, dst_addr} >= DEPTH_L);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output below is decoded from registered state and registers only,
    // so an asynchronous reset clears them at once and mem_write can never glitch.
    always_comb begin
        state_nx  = state;
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_bad)   state_nx = DONE;
                    else if (mode) state_nx = WRITE;
                    else           state_nx = READ;
                end
            end
            READ: begin
                mem_addr = src_ptr;
                state_nx = abort ? DONE : WRITE;
            end
            WRITE: begin
                mem_addr  = dst_ptr;
                mem_write = 1'b1;
                mem_wdata = mode_q ? fill_q : hold_q;
                if (abort || remaining == AW'(1)) state_nx = DONE;
                else if (mode_q)                  state_nx = WRITE;
                else                              state_nx = READ;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            fill_q    <= '0;
            hold_q    <= '0;
            err_q     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        fill_q    <= fill_val;
                        err_q     <= req_bad;
                        remaining <= req_bad ? '0 : length;
                    end
                end
                READ: begin
                    if (abort) err_q  <= 1'b1;
                    else       hold_q <= mem_rdata;
                end
                WRITE: begin
                    // The write under way commits even when abort arrives with it.
                    src_ptr   <= inc_wrap(src_ptr);
                    dst_ptr   <= inc_wrap(dst_ptr);
                    remaining <= remaining - AW'(1);
                    if (abort) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == READ) || (state == WRITE);
    assign done = (state == DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Self-checking bench for ram_dma_engine: directed scenarios plus random copy/fill
// transfers compared against a byte-level RAM model.
module tb_ram_dma_engine;

    localparam int DEPTH = 96;
    localparam int AW    = 7;
    localparam int BOUND = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, mode, abort;
    logic [AW-1:0] src_addr, dst_addr, length;
    logic [7:0]    fill_val;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          busy, done, err;
    logic [AW-1:0] remaining;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] ram      [128];
    logic [7:0] init_mem [128];
    logic [7:0] ref_ram  [DEPTH];
    logic       init_en;
    wr_t        got_wr[$];
    wr_t        exp_wr[$];
    int         busy_total = 0;
    int         errors = 0;
    int         checks = 0;

    ram_dma_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_val(fill_val), .abort(abort),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_mem[i];
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_write) got_wr.push_back('{a: mem_addr, d: mem_wdata});
        if (busy) busy_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-level model: each byte is written in ascending order, reading the model's
    // current contents so overlapping copies see already-written bytes.
    task automatic model_xfer(input int m, input int s, input int d, input int l, input int fv);
        exp_wr.delete();
        if (l == 0 || l > DEPTH || s >= DEPTH || d >= DEPTH) return;
        for (int i = 0; i < l; i++) begin
            int a;
            logic [7:0] v;
            a = (d + i) % DEPTH;
            v = (m != 0) ? fv[7:0] : ref_ram[(s + i) % DEPTH];
            ref_ram[a] = v;
            exp_wr.push_back('{a: a[6:0], d: v});
        end
    endtask

    task automatic arm(input int m, input int s, input int d, input int l, input int fv);
        mode     = m[0];
        src_addr = s[6:0];
        dst_addr = d[6:0];
        length   = l[6:0];
        fill_val = fv[7:0];
        start    = 1'b1;
    endtask

    // Called just before the accepting edge; checks latency, writes, status and RAM.
    task automatic finish_xfer(input string tag, input int m, input int s, input int d,
                               input int l, input int fv);
        int n, wr0, busy0, exp_n, bad, mism, oor;
        bad   = (l == 0 || l > DEPTH || s >= DEPTH || d >= DEPTH) ? 1 : 0;
        exp_n = bad ? 0 : ((m != 0) ? l : 2 * l);
        model_xfer(m, s, d, l, fv);
        wr0   = got_wr.size();
        busy0 = busy_total;
        @(posedge clk); #1;
        start    = 1'b0;
        mode     = $urandom;
        src_addr = $urandom;
        dst_addr = $urandom;
        length   = $urandom;
        fill_val = $urandom;
        n = 0;
        while (done !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_err"}, err, bad);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_busy_cycles"}, busy_total - busy0, exp_n);
        chk({tag, "_nwrites"}, got_wr.size() - wr0, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr0 + i < got_wr.size(); i++)
            chk({tag, "_write"}, got_wr[wr0 + i], exp_wr[i]);
        mism = 0;
        oor  = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_ram[i]) mism++;
        for (int i = wr0; i < got_wr.size(); i++) if (int'(got_wr[i].a) >= DEPTH) oor++;
        chk({tag, "_ram_mismatch"}, mism, 0);
        chk({tag, "_oor_writes"}, oor, 0);
    endtask

    task automatic run_xfer(input string tag, input int m, input int s, input int d,
                            input int l, input int fv);
        @(posedge clk); #1;
        arm(m, s, d, l, fv);
        finish_xfer(tag, m, s, d, l, fv);
    endtask

    initial begin
        int wr0;
        for (int i = 0; i < 128; i++) init_mem[i] = (i < DEPTH) ? 8'($urandom) : 8'h00;
        init_mem[0] = 8'h33;
        init_mem[1] = 8'h22;
        for (int i = 0; i < DEPTH; i++) ref_ram[i] = init_mem[i];
        init_en = 1'b1;
        reset = 1'b0;
        start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_val = '0;

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        #9;
        init_en = 1'b0;
        reset   = 1'b1;

        run_xfer("fill_a5", 1, 0, 10, 4, 8'hA5);
        run_xfer("copy_2", 0, 0, 50, 2, 0);
        chk("copy_ram50", ram[50], 8'h33);
        chk("copy_ram51", ram[51], 8'h22);
        run_xfer("wrap_fill", 1, 0, 94, 4, 8'h11);

        run_xfer("err_len0", 1, 0, 5, 0, 8'hFF);
        repeat (3) @(posedge clk);
        #1 chk("err_hold", err, 1);
        run_xfer("err_len97", 0, 0, 5, 97, 0);
        run_xfer("err_dst100", 1, 0, 100, 4, 8'h77);
        run_xfer("err_src96", 0, 96, 0, 4, 0);
        run_xfer("len96_fill", 1, 0, 40, 96, 8'h3C);

        // Abort in the third WRITE of a ten-byte fill.
        @(posedge clk); #1;
        arm(1, 0, 20, 10, 8'h5C);
        wr0 = got_wr.size();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 20; i < 23; i++) ref_ram[i] = 8'h5C;
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
        chk("abort_remaining", remaining, 7);
        chk("abort_nwrites", got_wr.size() - wr0, 3);
        for (int i = 0; i < 3 && wr0 + i < got_wr.size(); i++)
            chk("abort_addr", got_wr[wr0 + i].a, 20 + i);
        @(posedge clk); #1;
        chk("abort_idle", busy | done, 0);

        // Reset during the first READ of a copy.
        @(posedge clk); #1;
        arm(0, 5, 60, 8, 0);
        wr0 = got_wr.size();
        @(posedge clk); #1;
        start = 1'b0;
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_remaining", remaining, 0);
        chk("midrst_mem_write", mem_write, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        arm(1, 0, 30, 3, 8'hC3);
        @(negedge clk);
        chk("midrst_nwrites", got_wr.size() - wr0, 0);
        reset = 1'b1;
        finish_xfer("post_rst_fill", 1, 0, 30, 3, 8'hC3);

        for (int k = 0; k < 20; k++) begin
            int m, s, d, l;
            m = $urandom_range(0, 1);
            s = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, DEPTH);
            run_xfer((m != 0) ? "rand_fill" : "rand_copy", m, s, d, l, $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
